// File: rtl/filter_video_gen.sv
// Test-pattern video source: counts a programmable raster and emits vs/hs/de
// timing with a selectable Y/U/V pattern, running whole frames between start and stop.
module filter_video_gen #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned H_SYNC     = 16,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned H_ACT      = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned V_ACT      = 480,
   parameter int unsigned V_FP       = 10
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic [1:0]            i_pattern,
   input  logic [DATA_WIDTH-1:0] i_y_flat,
   output logic                  o_vs,
   output logic                  o_hs,
   output logic                  o_de,
   output logic [DATA_WIDTH-1:0] o_y,
   output logic [DATA_WIDTH-1:0] o_u,
   output logic [DATA_WIDTH-1:0] o_v,
   output logic                  o_busy,
   output logic                  o_frame_done
);

   localparam int unsigned H_TOT    = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int unsigned V_TOT    = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int unsigned HW       = $clog2(H_TOT + 1);
   localparam int unsigned VW       = $clog2(V_TOT + 1);
   localparam int unsigned H_DE_BEG = H_SYNC + H_BP;
   localparam int unsigned H_DE_END = H_DE_BEG + H_ACT;
   localparam int unsigned V_DE_BEG = V_SYNC + V_BP;
   localparam int unsigned V_DE_END = V_DE_BEG + V_ACT;

   localparam logic [DATA_WIDTH-1:0] UV_MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] Y_MAX  = {DATA_WIDTH{1'b1}};

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [HW-1:0]           h_cnt, h_cnt_d;
   logic [VW-1:0]           v_cnt, v_cnt_d;
   logic                    stop_req, stop_req_d;
   logic [1:0]              pat_q, pat_d;
   logic [DATA_WIDTH-1:0]   flat_q, flat_d;

   logic                    vs_d, hs_d, de_d, busy_d, done_d;
   logic [DATA_WIDTH-1:0]   y_d, u_d, v_d;
   logic [DATA_WIDTH-1:0]   x_c, y_c;
   logic                    h_last, v_last, origin;

   assign h_last = (h_cnt == HW'(H_TOT - 1));
   assign v_last = (v_cnt == VW'(V_TOT - 1));
   assign origin = (h_cnt == '0) && (v_cnt == '0);
   assign x_c    = DATA_WIDTH'(h_cnt - HW'(H_DE_BEG));
   assign y_c    = DATA_WIDTH'(v_cnt - VW'(V_DE_BEG));

   // Next state, raster counters, frame-latched settings and next output values
   always_comb begin
      state_d    = state_q;
      h_cnt_d    = h_cnt;
      v_cnt_d    = v_cnt;
      stop_req_d = stop_req;
      pat_d      = pat_q;
      flat_d     = flat_q;
      vs_d       = 1'b0;
      hs_d       = 1'b0;
      de_d       = 1'b0;
      y_d        = '0;
      u_d        = '0;
      v_d        = '0;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_RUN;
               h_cnt_d = '0;
               v_cnt_d = '0;
            end
         end
         S_RUN: begin
            // Pattern settings only change on a frame boundary
            if (origin) begin
               pat_d  = i_pattern;
               flat_d = i_y_flat;
            end

            hs_d = (h_cnt < HW'(H_SYNC));
            vs_d = (v_cnt < VW'(V_SYNC));
            de_d = (h_cnt >= HW'(H_DE_BEG)) && (h_cnt < HW'(H_DE_END)) &&
                   (v_cnt >= VW'(V_DE_BEG)) && (v_cnt < VW'(V_DE_END));

            if (de_d) begin
               u_d = UV_MID;
               v_d = UV_MID;
               unique case (pat_d)
                  2'd0:    y_d = x_c;
                  2'd1:    y_d = y_c;
                  2'd2:    y_d = (x_c[3] ^ y_c[3]) ? Y_MAX : '0;
                  default: y_d = flat_d;
               endcase
            end

            done_d = h_last && v_last;

            if (i_stop) begin
               stop_req_d = 1'b1;
            end

            if (h_last) begin
               h_cnt_d = '0;
               v_cnt_d = v_last ? '0 : v_cnt + VW'(1);
            end else begin
               h_cnt_d = h_cnt + HW'(1);
            end

            // A stop seen on the final cycle still ends this frame
            if (h_last && v_last && (stop_req || i_stop)) begin
               state_d    = S_IDLE;
               stop_req_d = 1'b0;
            end
         end
      endcase

      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         h_cnt        <= '0;
         v_cnt        <= '0;
         stop_req     <= 1'b0;
         pat_q        <= '0;
         flat_q       <= '0;
         o_vs         <= 1'b0;
         o_hs         <= 1'b0;
         o_de         <= 1'b0;
         o_y          <= '0;
         o_u          <= '0;
         o_v          <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         state_q      <= state_d;
         h_cnt        <= h_cnt_d;
         v_cnt        <= v_cnt_d;
         stop_req     <= stop_req_d;
         pat_q        <= pat_d;
         flat_q       <= flat_d;
         o_vs         <= vs_d;
         o_hs         <= hs_d;
         o_de         <= de_d;
         o_y          <= y_d;
         o_u          <= u_d;
         o_v          <= v_d;
         o_busy       <= busy_d;
         o_frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_filter_video_gen.sv
// Directed bench for filter_video_gen on a small raster (H 2/2/8/2, V 1/1/4/1),
// with a second instance at H_ACT=16 for the checker pattern.
module tb_filter_video_gen;

   logic       clk = 1'b0;
   logic       rstn;
   logic       i_start;
   logic       i_stop;
   logic [1:0] i_pattern;
   logic [7:0] i_y_flat;

   logic       a_vs, a_hs, a_de, a_busy, a_done;
   logic [7:0] a_y, a_u, a_v;
   logic       b_vs, b_hs, b_de, b_busy, b_done;
   logic [7:0] b_y, b_u, b_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   filter_video_gen #(
      .DATA_WIDTH(8), .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
      .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1)
   ) dut (
      .clk(clk), .rstn(rstn), .i_start(i_start), .i_stop(i_stop),
      .i_pattern(i_pattern), .i_y_flat(i_y_flat),
      .o_vs(a_vs), .o_hs(a_hs), .o_de(a_de), .o_y(a_y), .o_u(a_u), .o_v(a_v),
      .o_busy(a_busy), .o_frame_done(a_done)
   );

   filter_video_gen #(
      .DATA_WIDTH(8), .H_SYNC(2), .H_BP(2), .H_ACT(16), .H_FP(2),
      .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1)
   ) dut2 (
      .clk(clk), .rstn(rstn), .i_start(i_start), .i_stop(i_stop),
      .i_pattern(i_pattern), .i_y_flat(i_y_flat),
      .o_vs(b_vs), .o_hs(b_hs), .o_de(b_de), .o_y(b_y), .o_u(b_u), .o_v(b_v),
      .o_busy(b_busy), .o_frame_done(b_done)
   );

   // {vs, hs, de, y, u, v, frame_done, busy}
   function automatic logic [28:0] obs(input bit sel2);
      return sel2 ? {b_vs, b_hs, b_de, b_y, b_u, b_v, b_done, b_busy}
                  : {a_vs, a_hs, a_de, a_y, a_u, a_v, a_done, a_busy};
   endfunction

   task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input int got, input int exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      i_start = 1'b0;
      i_stop  = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   // Leaves the bench looking at the output for raster (0,0)
   task automatic start_run();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
   endtask

   task automatic idle_chk(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s c%0d", tag, k), obs(1'b0), 29'd0);
         tick();
      end
   endtask

   // Checks ncyc consecutive output cycles of one frame against the raster model.
   // stop_at / chg_at: cycle index on which i_stop pulses / i_pattern changes.
   task automatic frame_chk(input string name, input bit sel2, input int ncyc,
                            input int pat, input logic [7:0] flat, input int stop_at,
                            input bit last, input int chg_at, input logic [1:0] chg_pat);
      int htot, hact, nfull, h, v;
      int vs_n, hs_n, de_n, done_n;
      logic e_vs, e_hs, e_de, e_done, e_busy;
      logic [7:0] x, y, ey, eu;
      logic [28:0] o;
      htot   = sel2 ? 22 : 14;
      hact   = sel2 ? 16 : 8;
      nfull  = htot * 7;
      vs_n   = 0;
      hs_n   = 0;
      de_n   = 0;
      done_n = 0;
      for (int idx = 0; idx < ncyc; idx++) begin
         h      = idx % htot;
         v      = idx / htot;
         e_vs   = (v < 1);
         e_hs   = (h < 2);
         e_de   = (h >= 4) && (h < 4 + hact) && (v >= 2) && (v < 6);
         x      = 8'(h - 4);
         y      = 8'(v - 2);
         ey     = 8'h00;
         eu     = 8'h00;
         if (e_de) begin
            eu = 8'h80;
            case (pat)
               0:       ey = x;
               1:       ey = y;
               2:       ey = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
               default: ey = flat;
            endcase
         end
         e_done = (idx == nfull - 1);
         e_busy = !(last && (idx == nfull - 1));
         o = obs(sel2);
         check($sformatf("%s h%0d v%0d", name, h, v), o,
               {e_vs, e_hs, e_de, ey, eu, eu, e_done, e_busy});
         vs_n   += int'(o[28]);
         hs_n   += int'(o[27]);
         de_n   += int'(o[26]);
         done_n += int'(o[1]);
         i_stop = (idx == stop_at);
         if (idx == chg_at) i_pattern = chg_pat;
         tick();
      end
      i_stop = 1'b0;
      if (ncyc == nfull) begin
         check_cnt({name, " vs_count"}, vs_n, htot);
         check_cnt({name, " hs_count"}, hs_n, 14);
         check_cnt({name, " de_count"}, de_n, hact * 4);
         check_cnt({name, " done_count"}, done_n, 1);
      end
   endtask

   initial begin
      rstn      = 1'b0;
      i_start   = 1'b0;
      i_stop    = 1'b0;
      i_pattern = 2'd0;
      i_y_flat  = 8'h5A;

      // Reset and idle without start
      tick();
      check("rst dut", obs(1'b0), 29'd0);
      check("rst dut2", obs(1'b1), 29'd0);
      rstn = 1'b1;
      for (int k = 0; k < 200; k++) begin
         check($sformatf("idle c%0d", k), obs(1'b0), 29'd0);
         check($sformatf("idle2 c%0d", k), obs(1'b1), 29'd0);
         tick();
      end

      // Back-to-back frames: ramp, ramp (pattern changed mid-frame), v-ramp, flat then stop
      i_pattern = 2'd0;
      start_run();
      frame_chk("p0f1", 1'b0, 98, 0, 8'h5A, -1, 1'b0, -1, 2'd0);
      frame_chk("p0f2", 1'b0, 98, 0, 8'h5A, -1, 1'b0, 50, 2'd1);
      frame_chk("p1",   1'b0, 98, 1, 8'h5A, -1, 1'b0, 60, 2'd3);
      frame_chk("p3",   1'b0, 98, 3, 8'h5A, 40, 1'b1, -1, 2'd0);
      idle_chk("after p3 stop", 10);

      // Pattern 0 -> 3 mid-frame: current frame stays ramp, next is flat
      do_reset();
      i_pattern = 2'd0;
      i_y_flat  = 8'h5A;
      start_run();
      frame_chk("latch f1", 1'b0, 98, 0, 8'h5A, -1, 1'b0, 30, 2'd3);
      frame_chk("latch f2", 1'b0, 98, 3, 8'h5A, 20, 1'b1, -1, 2'd0);
      idle_chk("after latch", 5);

      // Stop pulse mid-frame 2: frame 2 completes, then idle
      do_reset();
      i_pattern = 2'd0;
      start_run();
      frame_chk("stop f1", 1'b0, 98, 0, 8'h5A, -1, 1'b0, -1, 2'd0);
      frame_chk("stop f2", 1'b0, 98, 0, 8'h5A, 45, 1'b1, -1, 2'd0);
      idle_chk("after stop f2", 10);

      // Stop sampled at the same edge that emits frame_done
      do_reset();
      start_run();
      frame_chk("stop last", 1'b0, 98, 0, 8'h5A, 96, 1'b1, -1, 2'd0);
      idle_chk("after stop last", 10);

      // i_start held high: one idle cycle between frames
      do_reset();
      i_start = 1'b1;
      tick();
      tick();
      frame_chk("hold f1", 1'b0, 98, 0, 8'h5A, 10, 1'b1, -1, 2'd0);
      check("hold gap", obs(1'b0), 29'd1);
      tick();
      i_start = 1'b0;
      frame_chk("hold f2", 1'b0, 98, 0, 8'h5A, 5, 1'b1, -1, 2'd0);
      idle_chk("after hold", 5);

      // Checker on the H_ACT=16 instance
      do_reset();
      i_pattern = 2'd2;
      start_run();
      frame_chk("p2", 1'b1, 154, 2, 8'h5A, -1, 1'b0, -1, 2'd0);

      // Asynchronous reset at h=5, v=3
      do_reset();
      i_pattern = 2'd0;
      start_run();
      frame_chk("pre rst", 1'b0, 47, 0, 8'h5A, -1, 1'b0, -1, 2'd0);
      rstn = 1'b0;
      #1;
      check("async rst", obs(1'b0), 29'd0);
      tick();
      rstn = 1'b1;
      tick();
      idle_chk("after async rst", 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
